servo_pwm_multi: RTL and testbench

SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

---
 rtl/servo_pwm_multi.sv | 127 ++++++++++++
 tb/tb_servo_pwm_multi.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator.
// One shared frame counter; each channel has a pending position that is
// written at any time and an active position copied in only at the frame
// wrap, so a pulse in progress is never cut short or stretched.
module servo_pwm_multi #(
  parameter int NCH          = 2,
  parameter int W            = 8,
  parameter int PERIOD_TICKS = 240000,
  parameter int MIN_TICKS    = 12000,
  parameter int STEP_TICKS   = 47,
  parameter int LED_FRAMES   = 25
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     wr_en,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_ch,
  input  logic [W-1:0]                             wr_pos,
  input  logic [NCH-1:0]                           ch_en,
  output logic [NCH-1:0]                           servo,
  output logic                                     frame_tick,
  output logic                                     led
);

  localparam int CNTW = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  // One spare bit so the pulse width and the compare never wrap.
  localparam int PW   = CNTW + 1;
  localparam int LFW  = (LED_FRAMES > 1) ? $clog2(LED_FRAMES) : 1;

  typedef longint unsigned u64_t;
  localparam u64_t MAX_PULSE = u64_t'(MIN_TICKS) +
                               ((u64_t'(1) << W) - u64_t'(1)) * u64_t'(STEP_TICKS);

  localparam logic [W-1:0]     POS_MID  = W'(1) << (W - 1);
  localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(PERIOD_TICKS - 1);
  localparam logic [LFW-1:0]   LED_LAST = LFW'(LED_FRAMES - 1);

  if (NCH < 1 || NCH > 16) begin : g_bad_nch
    $error("servo_pwm_multi: NCH must be in 1..16");
  end
  if (W < 1) begin : g_bad_w
    $error("servo_pwm_multi: W must be at least 1");
  end
  if (LED_FRAMES < 1) begin : g_bad_led
    $error("servo_pwm_multi: LED_FRAMES must be at least 1");
  end
  if (MAX_PULSE >= u64_t'(PERIOD_TICKS)) begin : g_bad_timing
    $error("servo_pwm_multi: longest pulse does not fit inside the frame");
  end

  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [LFW-1:0]          lcnt_q, lcnt_d;
  logic                    led_q, led_d;
  logic [NCH-1:0][W-1:0]   pend_q, pend_d;
  logic [NCH-1:0][W-1:0]   act_q, act_d;
  logic [NCH-1:0]          en_act_q, en_act_d;
  logic [NCH-1:0]          servo_q, servo_d;
  logic [PW-1:0]           pulse_w [NCH];
  logic                    wrap;
  logic                    frame_start;

  assign wrap        = (cnt_q == CNT_LAST);
  assign frame_start = (cnt_q == '0);

  // Pulse width per channel from the position that will be active after this edge.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      pulse_w[i] = PW'(MIN_TICKS) + PW'(act_d[i]) * PW'(STEP_TICKS);
    end
  end

  // Next-state logic for counters, position registers and outputs.
  always_comb begin
    cnt_d    = wrap ? '0 : cnt_q + CNTW'(1);

    pend_d   = pend_q;
    if (wr_en && (32'(wr_ch) < NCH)) begin
      pend_d[wr_ch] = wr_pos;
    end

    // Load from pend_d so a write on the wrap cycle lands in this frame.
    act_d    = wrap ? pend_d : act_q;
    en_act_d = wrap ? ch_en  : en_act_q;

    lcnt_d   = lcnt_q;
    led_d    = led_q;
    if (frame_start) begin
      if (lcnt_q == LED_LAST) begin
        lcnt_d = '0;
        led_d  = ~led_q;
      end else begin
        lcnt_d = lcnt_q + LFW'(1);
      end
    end

    // Pre-edge count against post-load width: high for cnt = 1..pulse.
    servo_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      servo_d[i] = en_act_d[i] && ({1'b0, cnt_q} < pulse_w[i]);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      lcnt_q   <= '0;
      led_q    <= 1'b0;
      pend_q   <= {NCH{POS_MID}};
      act_q    <= {NCH{POS_MID}};
      en_act_q <= '0;
      servo_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      lcnt_q   <= lcnt_d;
      led_q    <= led_d;
      pend_q   <= pend_d;
      act_q    <= act_d;
      en_act_q <= en_act_d;
      servo_q  <= servo_d;
    end
  end

  assign servo      = servo_q;
  assign frame_tick = !rst && frame_start;
  assign led        = led_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: a negedge monitor measures every frame's
// pulses; tests push expected frames and compare them as frames complete.
`timescale 1ns/1ps
module tb_servo_pwm_multi;

  localparam int CLK_P  = 10;
  localparam int PERIOD = 100;
  localparam int LEDF   = 2;

  typedef struct packed {
    logic [2:0][7:0] w;
    logic [2:0][7:0] f;
    logic [2:0]      c;
  } frame_rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [0:0] wr_ch = '0;
  logic [3:0] wr_pos = '0;
  logic [1:0] ch_en = '0;
  logic [1:0] servo;
  logic       frame_tick;
  logic       led;

  logic       wr_en3 = 1'b0;
  logic [1:0] wr_ch3 = '0;
  logic [3:0] wr_pos3 = '0;
  logic [2:0] ch_en3 = 3'b111;
  logic [2:0] servo3;
  logic       ft3;
  logic       led3;

  int         checks = 0;
  int         passed = 0;
  time        t_ft;
  int         ft_seen = 0;

  frame_rec_t obs0[$], obs1[$], exp0[$], exp1[$];
  frame_rec_t cur[2];
  int         moff[2];
  logic [2:0] mprev[2];
  bit         mact[2];

  always #(CLK_P / 2) clk = ~clk;

  servo_pwm_multi #(
    .NCH(2), .W(4), .PERIOD_TICKS(PERIOD), .MIN_TICKS(10), .STEP_TICKS(1), .LED_FRAMES(LEDF)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pos(wr_pos),
    .ch_en(ch_en), .servo(servo), .frame_tick(frame_tick), .led(led)
  );

  // Three-channel copy so an out-of-range channel index is representable.
  servo_pwm_multi #(
    .NCH(3), .W(4), .PERIOD_TICKS(PERIOD), .MIN_TICKS(10), .STEP_TICKS(1), .LED_FRAMES(LEDF)
  ) dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_pos(wr_pos3),
    .ch_en(ch_en3), .servo(servo3), .frame_tick(ft3), .led(led3)
  );

  function automatic frame_rec_t mk(input int a, input int b, input int c);
    frame_rec_t r;
    r = '0;
    r.w[0] = 8'(a);
    r.w[1] = 8'(b);
    r.w[2] = 8'(c);
    return r;
  endfunction

  task automatic mon_step(input int id, input logic r, input logic ft, input logic [2:0] sv);
    frame_rec_t done;
    if (r !== 1'b0) begin
      mact[id] = 1'b0;
      return;
    end
    if (ft === 1'b1) begin
      if (mact[id]) begin
        done = cur[id];
        if (id == 0) obs0.push_back(done);
        else         obs1.push_back(done);
      end
      cur[id]   = '0;
      cur[id].c = '1;
      moff[id]  = 0;
      mprev[id] = '0;
      mact[id]  = 1'b1;
    end else begin
      moff[id]++;
    end
    if (mact[id]) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (sv[ch] === 1'b1) begin
          if (cur[id].w[ch] == 8'd0) cur[id].f[ch] = 8'(moff[id]);
          else if (mprev[id][ch] !== 1'b1) cur[id].c[ch] = 1'b0;
          cur[id].w[ch] = cur[id].w[ch] + 8'd1;
        end
      end
      mprev[id] = sv;
    end
  endtask

  always @(negedge clk) mon_step(0, rst, frame_tick, {1'b0, servo});
  always @(negedge clk) mon_step(1, rst, ft3, servo3);

  always @(negedge clk) begin
    if (rst) ft_seen = 0;
    else if (frame_tick === 1'b1) ft_seen++;
  end

  task automatic get_frame(input int id, output frame_rec_t r, output bit got);
    int n;
    n   = 0;
    got = 1'b0;
    r   = '0;
    while (((id == 0) ? obs0.size() : obs1.size()) == 0 && n < 250) begin
      @(negedge clk); #1;
      n++;
    end
    if (id == 0 && obs0.size() > 0) begin
      r = obs0.pop_front();
      got = 1'b1;
    end else if (id == 1 && obs1.size() > 0) begin
      r = obs1.pop_front();
      got = 1'b1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (servo !== 2'b00 || led !== 1'b0 || frame_tick !== 1'b0)
        $display("FAIL reset_hold cyc%0d: servo=%b led=%b frame_tick=%b, required servo=00 led=0 frame_tick=0",
                 i, servo, led, frame_tick);
      else passed++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (frame_tick !== 1'b1)
      $display("FAIL reset_first_tick: frame_tick=%b, required 1", frame_tick);
    else passed++;
    t_ft = $time;
    exp0.push_back(mk(0, 0, 0));
  endtask

  task automatic test_basic_pulse();
    int n;
    time dt;
    frame_rec_t r, e;
    bit got;
    @(posedge clk); #1;
    ch_en = 2'b01; wr_en = 1'b1; wr_ch = 1'b0; wr_pos = 4'd5;
    exp0.push_back(mk(15, 0, 0));
    @(posedge clk); #1;
    wr_en = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (frame_tick !== 1'b1 && n < 250);
    dt = $time - t_ft;
    checks++;
    if (dt !== time'(PERIOD * CLK_P))
      $display("FAIL frame_period: %0t ns between ticks, required %0d ns", dt, PERIOD * CLK_P);
    else passed++;
    get_frame(0, r, got);
    e = exp0.pop_front();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (!got || r.w[i] !== e.w[i] || (e.w[i] != 0 && (r.f[i] !== 8'd1 || r.c[i] !== 1'b1)))
        $display("FAIL frame0_no_pulse ch%0d: width=%0d start=%0d contig=%b got=%b, required width=%0d",
                 i, r.w[i], r.f[i], r.c[i], got, e.w[i]);
      else passed++;
    end
  endtask

  task automatic test_mid_frame_update();
    frame_rec_t r, e;
    bit got;
    repeat (8) begin @(posedge clk); #1; end
    wr_en = 1'b1; wr_ch = 1'b0; wr_pos = 4'd15;
    exp0.push_back(mk(25, 0, 0));
    @(posedge clk); #1;
    wr_en = 1'b0;
    get_frame(0, r, got);
    e = exp0.pop_front();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (!got || r.w[i] !== e.w[i] || (e.w[i] != 0 && (r.f[i] !== 8'd1 || r.c[i] !== 1'b1)))
        $display("FAIL basic_pulse_frame1 ch%0d: width=%0d start=%0d contig=%b got=%b, required width=%0d start=1",
                 i, r.w[i], r.f[i], r.c[i], got, e.w[i]);
      else passed++;
    end
  endtask

  task automatic test_boundary_write();
    frame_rec_t r, e;
    bit got;
    repeat (99) begin @(posedge clk); #1; end
    ch_en = 2'b11; wr_en = 1'b1; wr_ch = 1'b1; wr_pos = 4'd0;
    exp0.push_back(mk(25, 10, 0));
    @(posedge clk); #1;
    wr_en = 1'b0;
    checks++;
    if (frame_tick !== 1'b1)
      $display("FAIL wrap_tick: frame_tick=%b after cnt 99, required 1", frame_tick);
    else passed++;
    for (int k = 0; k < 2; k++) begin
      get_frame(0, r, got);
      e = exp0.pop_front();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (!got || r.w[i] !== e.w[i] || (e.w[i] != 0 && (r.f[i] !== 8'd1 || r.c[i] !== 1'b1)))
          $display("FAIL boundary_frame%0d ch%0d: width=%0d start=%0d contig=%b got=%b, required width=%0d start=1",
                   k + 2, i, r.w[i], r.f[i], r.c[i], got, e.w[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_illegal_channel();
    frame_rec_t r, e;
    bit got;
    obs1.delete();
    @(posedge clk); #1;
    wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_pos3 = 4'd9;
    @(posedge clk); #1;
    wr_en3 = 1'b0;
    exp1.push_back(mk(18, 18, 18));
    exp1.push_back(mk(18, 18, 18));
    for (int k = 0; k < 2; k++) begin
      get_frame(1, r, got);
      e = exp1.pop_front();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (!got || r.w[i] !== e.w[i] || r.f[i] !== 8'd1 || r.c[i] !== 1'b1)
          $display("FAIL illegal_ch_frame%0d ch%0d: width=%0d start=%0d contig=%b got=%b, required width=%0d start=1",
                   k, i, r.w[i], r.f[i], r.c[i], got, e.w[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_heartbeat();
    int n;
    logic exp_led;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk); #1;
        n++;
      end while (frame_tick !== 1'b1 && n < 250);
      exp_led = 1'(((ft_seen - 1) / LEDF) % 2);
      checks++;
      if (frame_tick !== 1'b1 || led !== exp_led)
        $display("FAIL heartbeat tick%0d: led=%b frame_tick=%b, required led=%b frame_tick=1",
                 ft_seen, led, frame_tick, exp_led);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_pulse();
    int n;
    time dt;
    frame_rec_t r, e;
    bit got;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1; wr_en = 1'b1; wr_ch = 1'b0; wr_pos = 4'd3;
    @(negedge clk);
    checks++;
    if (servo !== 2'b11)
      $display("FAIL pulse_before_reset: servo=%b, required 11", servo);
    else passed++;
    @(negedge clk);
    checks++;
    if (servo !== 2'b00 || frame_tick !== 1'b0)
      $display("FAIL reset_kills_pulse: servo=%b frame_tick=%b, required servo=00 frame_tick=0", servo, frame_tick);
    else passed++;
    repeat (2) begin @(posedge clk); end
    #1;
    wr_en = 1'b0;
    obs0.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (frame_tick !== 1'b1 || led !== 1'b0)
      $display("FAIL restart_tick: frame_tick=%b led=%b, required frame_tick=1 led=0", frame_tick, led);
    else passed++;
    t_ft = $time;
    exp0.push_back(mk(0, 0, 0));
    exp0.push_back(mk(18, 18, 0));
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (frame_tick !== 1'b1 && n < 250);
    dt = $time - t_ft;
    checks++;
    if (dt !== time'(PERIOD * CLK_P))
      $display("FAIL restart_period: %0t ns between ticks, required %0d ns", dt, PERIOD * CLK_P);
    else passed++;
    for (int k = 0; k < 2; k++) begin
      get_frame(0, r, got);
      e = exp0.pop_front();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (!got || r.w[i] !== e.w[i] || (e.w[i] != 0 && (r.f[i] !== 8'd1 || r.c[i] !== 1'b1)))
          $display("FAIL restart_frame%0d ch%0d: width=%0d start=%0d contig=%b got=%b, required width=%0d start=1",
                   k, i, r.w[i], r.f[i], r.c[i], got, e.w[i]);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_pulse();
    test_mid_frame_update();
    test_boundary_write();
    test_illegal_channel();
    test_heartbeat();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #(400000);
    $display("FAIL watchdog: simulation did not complete, passed=%0d total=%0d", passed, checks);
    $fatal(1);
  end

endmodule
